// File: rtl/hazard3_trigger_break_ctrl_pkg.sv
// Shared constants and types for the breakpoint/haltreq break controller.
// Combinational only: no latency, no state.
// No flow control: types and helpers only.
package hazard3_trigger_break_ctrl_pkg;

  // dcsr.cause encodings driven alongside a Debug-mode break
  localparam logic [2:0] DCSR_CAUSE_NONE    = 3'd0;
  localparam logic [2:0] DCSR_CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] DCSR_CAUSE_HALTREQ = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2,
    ST_SKIP    = 2'd3
  } brk_state_t;

  // Which source the pending/active break came from
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_D    = 2'd1,
    SRC_H    = 2'd2,
    SRC_M    = 2'd3
  } brk_src_t;

  // M-mode breaks carry no dcsr.cause
  function automatic logic [2:0] cause_of(brk_src_t s);
    case (s)
      SRC_D:   return DCSR_CAUSE_TRIGGER;
      SRC_H:   return DCSR_CAUSE_HALTREQ;
      default: return DCSR_CAUSE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hazard3_priority_sel.sv
// Fixed-priority select among three break sources (hi > mid > lo).
// Latency: purely combinational, zero cycles.
// No backpressure: grants follow requests in the same cycle.
module hazard3_priority_sel (
  input  logic req_hi,
  input  logic req_mid,
  input  logic req_lo,
  output logic gnt_hi,
  output logic gnt_mid,
  output logic gnt_lo,
  output logic gnt_any
);

  // One-hot grant to the highest-priority active request
  always_comb begin
    gnt_hi  = req_hi;
    gnt_mid = req_mid & ~req_hi;
    gnt_lo  = req_lo & ~req_hi & ~req_mid;
    gnt_any = req_hi | req_mid | req_lo;
  end

endmodule

// File: rtl/hazard3_trigger_break_ctrl.sv
// Arbitrates D-trigger / haltreq / M-trigger into one break request, records sticky hits, skips re-match after return.
// Latency: match in cycle n gives break_req in cycle n+1.
// Backpressure: break_req held until break_ack (or flush); matches arriving meanwhile are dropped.
module hazard3_trigger_break_ctrl
  import hazard3_trigger_break_ctrl_pkg::*;
#(
  parameter int BREAKPOINT_TRIGGERS = 4,
  parameter int W_ADDR              = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BREAKPOINT_TRIGGERS-1:0] match_m,
  input  logic [BREAKPOINT_TRIGGERS-1:0] match_d,
  input  logic                           trig_m_en,
  input  logic                           pc_valid,
  input  logic [W_ADDR-1:0]              pc,
  input  logic                           d_mode,
  input  logic                           haltreq,
  input  logic                           flush,
  input  logic                           break_ack,
  input  logic                           mret,
  input  logic                           dret,
  input  logic                           instr_retire,
  input  logic [W_ADDR-1:0]              retire_pc,
  input  logic [BREAKPOINT_TRIGGERS-1:0] hit_clr,
  output logic                           break_req,
  output logic                           break_d_mode,
  output logic [2:0]                     break_cause,
  output logic [BREAKPOINT_TRIGGERS-1:0] hit
);

  brk_state_t                     state, state_nxt;
  brk_src_t                       src;
  logic [BREAKPOINT_TRIGGERS-1:0] vec;
  logic [W_ADDR-1:0]              skip_pc;

  logic                           skip_hit;
  logic                           pc_gate;
  logic [BREAKPOINT_TRIGGERS-1:0] md, mm;
  logic                           gnt_d, gnt_h, gnt_m, gnt_any;
  logic                           take;
  logic                           acked;

  // Qualify raw matches: nothing fires in Debug mode, and the PC just returned to is masked while skipping
  always_comb begin
    skip_hit = (state == ST_SKIP) && (pc == skip_pc);
    pc_gate  = pc_valid & ~d_mode & ~skip_hit;
    md       = match_d & {BREAKPOINT_TRIGGERS{pc_gate}};
    mm       = match_m & {BREAKPOINT_TRIGGERS{pc_gate & trig_m_en}};
  end

  hazard3_priority_sel u_sel (
    .req_hi  (|md),
    .req_mid (haltreq & ~d_mode),
    .req_lo  (|mm),
    .gnt_hi  (gnt_d),
    .gnt_mid (gnt_h),
    .gnt_lo  (gnt_m),
    .gnt_any (gnt_any)
  );

  // A new break can only be launched from IDLE or SKIP
  always_comb begin
    take  = gnt_any && ((state == ST_IDLE) || (state == ST_SKIP));
    acked = (state == ST_REQ) && break_ack;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: ack beats flush in REQ; each trigger source leaves HANDLER only on its own return
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take) state_nxt = ST_REQ;
      ST_REQ: begin
        if (break_ack)  state_nxt = ST_HANDLER;
        else if (flush) state_nxt = ST_IDLE;
      end
      ST_HANDLER: begin
        if (src == SRC_M) begin
          if (mret) state_nxt = ST_SKIP;
        end else if (dret) begin
          state_nxt = (src == SRC_H) ? ST_IDLE : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (take)
          state_nxt = ST_REQ;
        else if (flush || (instr_retire && (retire_pc == skip_pc)))
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch source, matching vector and PC on selection; sticky hits where set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src     <= SRC_NONE;
      vec     <= '0;
      skip_pc <= '0;
      hit     <= '0;
    end else begin
      if (take) begin
        skip_pc <= pc;
        if (gnt_d) begin
          src <= SRC_D;
          vec <= md;
        end else if (gnt_h) begin
          src <= SRC_H;
          vec <= '0;
        end else begin
          src <= SRC_M;
          vec <= mm;
        end
      end
      hit <= (hit & ~hit_clr) | (acked ? vec : '0);
    end
  end

  // Outputs: request fields are only meaningful while in REQ
  always_comb begin
    break_req    = (state == ST_REQ);
    break_d_mode = break_req && (src != SRC_M);
    break_cause  = break_req ? cause_of(src) : DCSR_CAUSE_NONE;
  end

endmodule

// File: tb/tb_hazard3_trigger_break_ctrl.sv
module tb_hazard3_trigger_break_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  match_m, match_d, hit_clr, hit;
  logic        trig_m_en, pc_valid, d_mode, haltreq, flush, break_ack;
  logic        mret, dret, instr_retire;
  logic [31:0] pc, retire_pc;
  logic        break_req, break_d_mode;
  logic [2:0]  break_cause;

  hazard3_trigger_break_ctrl #(.BREAKPOINT_TRIGGERS(4), .W_ADDR(32)) dut (
    .clk(clk), .rst(rst), .match_m(match_m), .match_d(match_d),
    .trig_m_en(trig_m_en), .pc_valid(pc_valid), .pc(pc), .d_mode(d_mode),
    .haltreq(haltreq), .flush(flush), .break_ack(break_ack), .mret(mret),
    .dret(dret), .instr_retire(instr_retire), .retire_pc(retire_pc),
    .hit_clr(hit_clr), .break_req(break_req), .break_d_mode(break_d_mode),
    .break_cause(break_cause), .hit(hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       dm;
    logic [2:0] cause;
    logic [3:0] vec;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] exp_hit;
  int         n_cmp;
  int         n_err;
  int         n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    match_m = '0; match_d = '0; hit_clr = '0; trig_m_en = 1'b1;
    pc_valid = 1'b0; pc = '0; d_mode = 1'b0; haltreq = 1'b0; flush = 1'b0;
    break_ack = 1'b0; mret = 1'b0; dret = 1'b0; instr_retire = 1'b0; retire_pc = '0;
  endtask

  // Waits (bounded) for break_req; n is the number of extra cycles needed
  task automatic wait_req(output int cyc);
    cyc = 0;
    while (!break_req && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) e = '0;
    else e = sb.pop_front();
  endtask

  task automatic ack_handler();
    break_ack = 1'b1;
    tick();
    break_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    n_cmp++; if (break_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", break_req); end
    n_cmp++; if ({break_d_mode, break_cause} !== 4'b0) begin n_err++; $display("FAIL reset_mode_cause: got %b/%0d want 0/0", break_d_mode, break_cause); end
    n_cmp++; if (hit !== 4'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0000", hit); end
    rst = 1'b0;
    exp_hit = '0;
    tick();
  endtask

  task automatic test_d_trigger_skip();
    match_d = 4'b0010; pc = 32'h100; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b0010});
    tick();
    match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL d_latency: got %0d extra cycles want 0", n); end
    n_cmp++; if ({break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL d_mode_cause: got %b/%0d want %b/%0d", break_d_mode, break_cause, e.dm, e.cause); end
    tick();
    n_cmp++; if (break_req !== 1'b1) begin n_err++; $display("FAIL d_hold: got %b want 1", break_req); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    n_cmp++; if (hit !== exp_hit || break_req !== 1'b0) begin n_err++; $display("FAIL d_ack_hit: got %b req %b want %b req 0", hit, break_req, exp_hit); end
    dret = 1'b1; tick(); dret = 1'b0;
    // Same PC must stay masked while skipping, including the retire cycle itself
    match_d = 4'b0010; pc = 32'h100; pc_valid = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (break_req !== 1'b0) begin n_err++; $display("FAIL skip_mask: got %b want 0", break_req); end
    instr_retire = 1'b1; retire_pc = 32'h100;
    tick();
    instr_retire = 1'b0;
    n_cmp++; if (break_req !== 1'b0) begin n_err++; $display("FAIL skip_retire_cycle: got %b want 0", break_req); end
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b0010});
    tick();
    match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL rematch: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    dret = 1'b1; tick(); dret = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_priority_d_over_m();
    hit_clr = 4'b1111; tick(); hit_clr = '0;
    exp_hit = '0;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL hit_clear_all: got %b want %b", hit, exp_hit); end
    match_m = 4'b0001; match_d = 4'b1000; pc = 32'h200; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b1000});
    tick();
    match_m = '0; match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL d_over_m: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL d_over_m_hit: got %b want %b", hit, exp_hit); end
    // mret must not end a D-mode handler: a fresh match at another PC stays ignored
    mret = 1'b1; tick(); mret = 1'b0;
    match_d = 4'b0001; pc = 32'h300; pc_valid = 1'b1;
    tick(); tick();
    n_cmp++; if (break_req !== 1'b0) begin n_err++; $display("FAIL mret_ignored: got %b want 0", break_req); end
    match_d = '0; pc_valid = 1'b0;
    dret = 1'b1; tick(); dret = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_m_enable();
    trig_m_en = 1'b0; match_m = 4'b0001; pc = 32'h400; pc_valid = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (break_req !== 1'b0) begin n_err++; $display("FAIL m_disabled: got %b want 0", break_req); end
    trig_m_en = 1'b1;
    sb.push_back('{dm: 1'b0, cause: 3'd0, vec: 4'b0001});
    tick();
    match_m = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL m_break: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL m_hit: got %b want %b", hit, exp_hit); end
    mret = 1'b1; tick(); mret = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_haltreq_and_flush();
    haltreq = 1'b1; match_m = 4'b0001; pc = 32'h500; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd3, vec: 4'b0000});
    tick();
    haltreq = 1'b0; match_m = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL haltreq: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL haltreq_hit: got %b want %b", hit, exp_hit); end
    // haltreq return goes to IDLE, so the same PC may match straight away
    dret = 1'b1; tick(); dret = 1'b0;
    match_d = 4'b0100; pc = 32'h500; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b0100});
    tick();
    match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL after_halt_match: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    flush = 1'b1; tick(); flush = 1'b0;
    n_cmp++; if (break_req !== 1'b0) begin n_err++; $display("FAIL flush_req: got %b want 0", break_req); end
    tick();
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL flush_hit: got %b want %b", hit, exp_hit); end
  endtask

  task automatic test_rst_mid_req();
    match_d = 4'b0100; pc = 32'h600; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b0100});
    tick();
    match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || break_req !== 1'b1) begin n_err++; $display("FAIL pre_rst_req: got extra %0d req %b want 0 req 1", n, break_req); end
    rst = 1'b1;
    #1;
    exp_hit = '0;
    n_cmp++; if ({break_req, break_d_mode, break_cause, hit} !== {2'b00, 3'd0, exp_hit}) begin n_err++; $display("FAIL rst_async: got req %b dm %b cause %0d hit %b want all 0", break_req, break_d_mode, break_cause, hit); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_hit_clr_race();
    match_d = 4'b0010; pc = 32'h700; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b0010});
    tick();
    match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL race_req: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    // ack, flush and hit_clr together: ack wins over flush, set wins over clear
    break_ack = 1'b1; flush = 1'b1; hit_clr = 4'b0010;
    tick();
    break_ack = 1'b0; flush = 1'b0; hit_clr = '0;
    exp_hit = (exp_hit & ~4'b0010) | e.vec;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL set_beats_clr: got %b want %b", hit, exp_hit); end
    dret = 1'b1; tick(); dret = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    hit_clr = 4'b0010; tick(); hit_clr = '0;
    exp_hit = exp_hit & ~4'b0010;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL hit_clr_alone: got %b want %b", hit, exp_hit); end
  endtask

  task automatic test_dmode_block();
    d_mode = 1'b1; match_d = 4'b0001; haltreq = 1'b1; pc = 32'h800; pc_valid = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (break_req !== 1'b0) begin n_err++; $display("FAIL dmode_block: got %b want 0", break_req); end
    d_mode = 1'b0; haltreq = 1'b0;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b0001});
    tick();
    match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL dmode_release: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    // Entering Debug mode does not cancel a request already raised
    d_mode = 1'b1;
    tick();
    n_cmp++; if (break_req !== 1'b1) begin n_err++; $display("FAIL dmode_keeps_req: got %b want 1", break_req); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL dmode_ack_hit: got %b want %b", hit, exp_hit); end
    dret = 1'b1; tick(); dret = 1'b0;
    d_mode = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    match_d = 4'b0100; pc = 32'h900; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b0100});
    tick();
    match_d = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL b2b_first: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    dret = 1'b1; tick(); dret = 1'b0;
    // From SKIP, a different PC is taken immediately
    match_d = 4'b1000; match_m = 4'b0010; pc = 32'h904; pc_valid = 1'b1;
    sb.push_back('{dm: 1'b1, cause: 3'd2, vec: 4'b1000});
    tick();
    match_d = '0; match_m = '0; pc_valid = 1'b0;
    wait_req(n); pop_exp();
    n_cmp++; if (n !== 0 || {break_d_mode, break_cause} !== {e.dm, e.cause}) begin n_err++; $display("FAIL b2b_second: got extra %0d %b/%0d want 0 %b/%0d", n, break_d_mode, break_cause, e.dm, e.cause); end
    ack_handler();
    exp_hit = exp_hit | e.vec;
    n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL b2b_hit: got %b want %b", hit, exp_hit); end
    dret = 1'b1; tick(); dret = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_hit = '0;
    test_reset();
    test_d_trigger_skip();
    test_priority_d_over_m();
    test_m_enable();
    test_haltreq_and_flush();
    test_rst_mid_req();
    test_hit_clr_race();
    test_dmode_block();
    test_back_to_back();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
